execute_exception_arbiter: RTL and testbench

EXECUTE_EXCEPTION_ARBITER -- requirements
Module: execute_exception_arbiter

---
 rtl/execute_exception_arbiter.sv | 160 ++++++++++++++++
 tb/tb_execute_exception_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/execute_exception_arbiter.sv
// Execute-stage exception arbiter: picks the highest-priority fault,
// holds it until the handler takes it, and escalates a second fault to a double fault.
`ifndef INT_NUM_DIVIDER_ERROR
`define INT_NUM_DIVIDER_ERROR 7'd0
`endif
`ifndef INT_NUM_INSTRUCTION_INVALID
`define INT_NUM_INSTRUCTION_INVALID 7'd6
`endif
`ifndef INT_NUM_PRIVILEGE_ERRPR
`define INT_NUM_PRIVILEGE_ERRPR 7'd13
`endif
`ifndef INT_NUM_PAGEFAULT
`define INT_NUM_PAGEFAULT 7'd14
`endif

module execute_exception_arbiter #(
  parameter int P_SRC_N = 4,
  parameter int P_NUM_W = 7,
  parameter logic [P_SRC_N*P_NUM_W-1:0] P_SRC_NUM = {
    `INT_NUM_DIVIDER_ERROR,
    `INT_NUM_INSTRUCTION_INVALID,
    `INT_NUM_PRIVILEGE_ERRPR,
    `INT_NUM_PAGEFAULT
  },
  parameter logic [P_NUM_W-1:0] P_DOUBLE_NUM = 7'h7F,
  parameter int P_CNT_W = 8
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iPREV_STATE_NORMAL,
  input  logic               iPREV_VALID,
  input  logic [P_SRC_N-1:0] iPREV_FAULT,
  input  logic [P_SRC_N-1:0] iFAULT_MASK,
  input  logic               iEXCEPT_ACK,
  input  logic               iEXCEPT_FLUSH,
  output logic               oEXCEPT_VALID,
  output logic [P_NUM_W-1:0] oEXCEPT_NUM,
  output logic [P_SRC_N-1:0] oEXCEPT_SRC,
  output logic               oDOUBLE_FAULT,
  output logic [P_CNT_W-1:0] oDROP_COUNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    DOUBLE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [P_NUM_W-1:0]   num_q, num_d;
  logic [P_SRC_N-1:0]   src_q, src_d;
  logic                 dbl_q, dbl_d;
  logic [P_CNT_W-1:0]   drop_q, drop_d;

  logic [P_SRC_N-1:0]   eff;
  logic [P_SRC_N-1:0]   win_oh;
  logic [P_NUM_W-1:0]   win_num;
  logic                 accept;
  logic                 found;

  assign eff    = iPREV_FAULT & ~iFAULT_MASK;
  assign accept = iPREV_VALID & iPREV_STATE_NORMAL & (|eff);

  // lowest asserted index wins
  always_comb begin
    win_oh  = '0;
    win_num = '0;
    found   = 1'b0;
    for (int i = 0; i < P_SRC_N; i++) begin
      if (eff[i] && !found) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_num   = P_SRC_NUM[i*P_NUM_W +: P_NUM_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    num_d   = num_q;
    src_d   = src_q;
    dbl_d   = dbl_q;
    drop_d  = drop_q;
    if (iEXCEPT_FLUSH) begin
      state_d = IDLE;
      valid_d = 1'b0;
      num_d   = '0;
      src_d   = '0;
      dbl_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = PEND;
            valid_d = 1'b1;
            num_d   = win_num;
            src_d   = win_oh;
            dbl_d   = 1'b0;
          end
        end
        PEND, DOUBLE: begin
          if (iEXCEPT_ACK && accept) begin
            state_d = PEND;
            valid_d = 1'b1;
            num_d   = win_num;
            src_d   = win_oh;
            dbl_d   = 1'b0;
          end else if (iEXCEPT_ACK) begin
            state_d = IDLE;
            valid_d = 1'b0;
            num_d   = '0;
            src_d   = '0;
            dbl_d   = 1'b0;
          end else if (accept) begin
            // the original source stays visible for the handler
            state_d = DOUBLE;
            num_d   = P_DOUBLE_NUM;
            dbl_d   = 1'b1;
            if (drop_q != {P_CNT_W{1'b1}})
              drop_d = drop_q + P_CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          num_d   = '0;
          src_d   = '0;
          dbl_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      num_q   <= '0;
      src_q   <= '0;
      dbl_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      num_q   <= num_d;
      src_q   <= src_d;
      dbl_q   <= dbl_d;
      drop_q  <= drop_d;
    end
  end

  assign oEXCEPT_VALID = valid_q;
  assign oEXCEPT_NUM   = num_q;
  assign oEXCEPT_SRC   = src_q;
  assign oDOUBLE_FAULT = dbl_q;
  assign oDROP_COUNT   = drop_q;

endmodule

// File: tb/tb_execute_exception_arbiter.sv
// Directed-vector bench for execute_exception_arbiter with a
// queue scoreboard drained by an independent monitor.
module tb_execute_exception_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       normal;
  logic       pvalid;
  logic [3:0] fault;
  logic [3:0] mask;
  logic       ack;
  logic       flush;
  logic       ev;
  logic [6:0] en;
  logic [3:0] es;
  logic       ed;
  logic [3:0] dc;

  typedef struct {
    int         id;
    logic       v;
    logic [6:0] n;
    logic [3:0] s;
    logic       d;
    logic [3:0] c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  execute_exception_arbiter #(
    .P_SRC_N     (4),
    .P_NUM_W     (7),
    .P_SRC_NUM   ({7'h13, 7'h12, 7'h11, 7'h10}),
    .P_DOUBLE_NUM(7'h7F),
    .P_CNT_W     (4)
  ) dut (
    .iCLOCK            (clk),
    .iRESET_SYNC       (rst),
    .iPREV_STATE_NORMAL(normal),
    .iPREV_VALID       (pvalid),
    .iPREV_FAULT       (fault),
    .iFAULT_MASK       (mask),
    .iEXCEPT_ACK       (ack),
    .iEXCEPT_FLUSH     (flush),
    .oEXCEPT_VALID     (ev),
    .oEXCEPT_NUM       (en),
    .oEXCEPT_SRC       (es),
    .oDOUBLE_FAULT     (ed),
    .oDROP_COUNT       (dc)
  );

  // monitor: each edge produces one response to compare
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (ev !== e.v || en !== e.n || es !== e.s ||
          ed !== e.d || dc !== e.c) begin
        errors++;
        $display("FAIL step%0d got v=%b n=%h s=%b d=%b c=%h want v=%b n=%h s=%b d=%b c=%h",
                 e.id, ev, en, es, ed, dc, e.v, e.n, e.s, e.d, e.c);
      end
    end
  end

  task automatic cyc(
    input logic       r,
    input logic       nm,
    input logic       pv,
    input logic [3:0] f,
    input logic [3:0] m,
    input logic       a,
    input logic       fl,
    input logic       xv,
    input logic [6:0] xn,
    input logic [3:0] xs,
    input logic       xd,
    input logic [3:0] xc
  );
    exp_t e;
    @(negedge clk);
    rst = r; normal = nm; pvalid = pv;
    fault = f; mask = m; ack = a; flush = fl;
    step++;
    e.id = step; e.v = xv; e.n = xn;
    e.s = xs; e.d = xd; e.c = xc;
    q.push_back(e);
  endtask

  // shorthand: a normal retiring fault
  task automatic flt(
    input logic [3:0] f, input logic [3:0] m,
    input logic a, input logic fl,
    input logic xv, input logic [6:0] xn,
    input logic [3:0] xs, input logic xd,
    input logic [3:0] xc
  );
    cyc(0, 1, 1, f, m, a, fl, xv, xn, xs, xd, xc);
  endtask

  initial begin
    int cnt;
    rst = 1; normal = 0; pvalid = 0;
    fault = 0; mask = 0; ack = 0; flush = 0;

    cyc(1, 1, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0);
    flt(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // basic capture and hold
    flt(4'b1010, 0, 0, 0, 1, 7'h11, 4'b0010, 0, 0);
    flt(0, 0, 0, 0, 1, 7'h11, 4'b0010, 0, 0);
    flt(0, 0, 0, 0, 1, 7'h11, 4'b0010, 0, 0);
    flt(0, 0, 1, 0, 0, 0, 0, 0, 0);
    flt(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // masking
    flt(4'b0011, 4'b0001, 0, 0, 1, 7'h11, 4'b0010, 0, 0);
    flt(0, 0, 1, 0, 0, 0, 0, 0, 0);
    flt(4'b0001, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
    // reach DOUBLE with drop=3, then reset
    flt(4'b0001, 0, 0, 0, 1, 7'h10, 4'b0001, 0, 0);
    flt(4'b1000, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 1);
    flt(4'b0100, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 2);
    flt(4'b0010, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 3);
    cyc(1, 1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
    // first cycle after reset accepts
    flt(4'b0001, 0, 0, 0, 1, 7'h10, 4'b0001, 0, 0);
    // ack with new fault same cycle
    flt(4'b0100, 0, 1, 0, 1, 7'h12, 4'b0100, 0, 0);
    // flush discards simultaneous fault
    flt(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    flt(4'b0001, 0, 0, 0, 1, 7'h10, 4'b0001, 0, 0);
    flt(4'b1000, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 1);
    flt(4'b0001, 0, 1, 1, 0, 0, 0, 0, 1);
    // idle pipeline faults ignored
    cyc(0, 0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 1);
    flt(4'b0010, 0, 0, 0, 1, 7'h11, 4'b0010, 0, 1);
    cyc(0, 0, 1, 4'b0001, 0, 0, 0, 1, 7'h11, 4'b0010, 0, 1);
    flt(4'b0001, 4'b0001, 0, 0, 1, 7'h11, 4'b0010, 0, 1);
    flt(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // saturation
    flt(4'b0001, 0, 0, 0, 1, 7'h10, 4'b0001, 0, 1);
    flt(4'b1000, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 2);
    cnt = 2;
    for (int k = 0; k < 20; k++) begin
      if (cnt < 15) cnt++;
      flt(4'b1000, 0, 0, 0, 1, 7'h7F, 4'b0001, 1, 4'(cnt));
    end
    // DOUBLE: ack with fault re-arms PEND
    flt(4'b0100, 0, 1, 0, 1, 7'h12, 4'b0100, 0, 4'hF);
    flt(0, 0, 1, 0, 0, 0, 0, 0, 4'hF);
    flt(0, 0, 0, 1, 0, 0, 0, 0, 4'hF);
    flt(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);

    begin
      int budget = 10;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain left=%0d want 0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
